// File: rtl/moore_tcount_n.sv
// Parametrised T-flip-flop Moore counter: up/down, sync load/clear, match output, sticky wrap flag.
// Optional saturating mode when MOORE_TCOUNT_SAT_EN is defined.
module moore_tcount_n #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] MATCH = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             res,
  input  logic             x_in,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  output logic [WIDTH-1:0] state,
  output logic             y_out,
  output logic             wrap_flag
);

  logic [WIDTH-1:0] t;
  logic             wrap;
  logic             carry;

  // Toggle enables: a bit flips once every lower bit is at its terminal value
  // (all ones counting up, all zeros counting down).
  always_comb begin
    t     = '0;
    wrap  = 1'b0;
    carry = 1'b1;
    if (load) begin
      t = state ^ load_val;
    end else if (x_in) begin
      wrap = up_dn ? (&state) : ~(|state);
      for (int i = 0; i < WIDTH; i++) begin
        t[i]  = carry;
        carry = carry & (up_dn ? state[i] : ~state[i]);
      end
`ifdef MOORE_TCOUNT_SAT_EN
      if (wrap) t = '0;
`else
`endif
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state     <= '0;
      wrap_flag <= 1'b0;
    end else if (clr) begin
      state     <= '0;
      wrap_flag <= 1'b0;
    end else begin
      state <= state ^ t;
      if (wrap) wrap_flag <= 1'b1;
    end
  end

  assign y_out = (state == MATCH);

endmodule
